// File: rtl/line_scanout.sv
// VGA scanout for the GPU line buffer: timing, palette lookup to RGB332, line swap/render requests.
// Optional status word (underrun flag, frame counter) enabled by defining LINE_SCANOUT_STATUS_EN.
module line_scanout #(
  parameter int          H_VISIBLE    = 640,
  parameter int          H_FRONT      = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BACK       = 48,
  parameter int          V_VISIBLE    = 480,
  parameter int          V_FRONT      = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BACK       = 33,
  parameter logic [15:0] PALETTE_ADDR = 16'h4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [7:0]  p_index,
  input  logic        render_busy,
  output logic        shift,
  output logic        swap,
  output logic        render_start,
  output logic [8:0]  render_line,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  rgb,
  input  logic [15:0] memaddr,
  input  logic        memwrite,
  input  logic [15:0] writedata,
  output logic [15:0] memdata
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_VIS_C  = 10'(H_VISIBLE);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  V_VIS_C  = 10'(V_VISIBLE);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_PRE    = 10'(V_TOTAL - 2);
  localparam logic [9:0]  VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [16:0] PAL_LO   = {1'b0, PALETTE_ADDR};
  localparam logic [16:0] PAL_HI   = PAL_LO + 17'd255;

  logic [9:0] hcnt, vcnt;
  logic [9:0] n1, n2;
  logic       visible, hs_now, vs_now, line_evt, rs_evt, pal_hit;

  logic [7:0] pal [256];

  logic [7:0] idx_p1;
  logic       vld_p1, hs_p1, vs_p1;

  assign visible  = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
  assign hs_now   = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
  assign vs_now   = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
  assign n1       = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
  assign n2       = (vcnt >= V_PRE) ? vcnt - V_PRE : vcnt + 10'd2;
  assign line_evt = !rst && pix_en && (hcnt == H_VIS_C);
  assign rs_evt   = line_evt && (n2 < V_VIS_C);
  assign shift    = !rst && pix_en && visible;
  assign swap     = line_evt && (n1 < V_VIS_C);
  assign pal_hit  = ({1'b0, memaddr} >= PAL_LO) && ({1'b0, memaddr} <= PAL_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= 10'd0;
      vcnt <= 10'd0;
    end else if (pix_en) begin
      if (hcnt == H_LAST) begin
        hcnt <= 10'd0;
        vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      idx_p1 <= 8'h00;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      rgb    <= 8'h00;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
    end else if (pix_en) begin
      // stage 1: capture index and the timing of the pixel it belongs to
      vld_p1 <= visible;
      idx_p1 <= p_index;
      hs_p1  <= hs_now;
      vs_p1  <= vs_now;
      // stage 2: palette lookup, blanked outside the visible area
      rgb    <= vld_p1 ? pal[idx_p1] : 8'h00;
      hsync  <= hs_p1;
      vsync  <= vs_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      render_start <= 1'b0;
      render_line  <= 9'd0;
    end else begin
      render_start <= rs_evt;
      if (rs_evt) render_line <= n2[8:0];
    end
  end

  // Palette contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (pal_hit && memwrite) pal[memaddr[7:0]] <= writedata[7:0];
  end

`ifdef LINE_SCANOUT_STATUS_EN
  localparam logic [15:0] STAT_ADDR = PALETTE_ADDR + 16'd256;

  logic       stat_hit;
  logic       underrun;
  logic [9:0] frame_cnt;
  logic       unused_in;

  assign stat_hit  = (memaddr == STAT_ADDR);
  assign unused_in = ^{writedata[15:8], n2[9]};

  // A new underrun in the same clk as a status read wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun  <= 1'b0;
      frame_cnt <= 10'd0;
    end else begin
      if (pix_en && (hcnt == H_LAST) && (vcnt == V_LAST)) frame_cnt <= frame_cnt + 10'd1;
      if (swap && render_busy) underrun <= 1'b1;
      else if (stat_hit)       underrun <= 1'b0;
    end
  end
`else
  logic unused_in;
  assign unused_in = ^{writedata[15:8], n2[9], render_busy};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      memdata <= 16'h0000;
    end else if (pal_hit) begin
      memdata <= {8'h00, pal[memaddr[7:0]]};
`ifdef LINE_SCANOUT_STATUS_EN
    end else if (stat_hit) begin
      memdata <= {underrun, 5'b0, frame_cnt};
`endif
    end
  end

endmodule

// File: tb/tb_line_scanout.sv
// Bench for line_scanout with a reduced raster; a tick-count model predicts every output each clk.
module tb_line_scanout;
  localparam int HV = 32, HF = 4, HS = 8, HB = 4, HT = HV + HF + HS + HB;
  localparam int VV = 20, VF = 3, VS = 2, VB = 5, VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [15:0] PAL = 16'h4000;

  logic        clk = 1'b0, rst = 1'b1, pix_en = 1'b0, render_busy = 1'b0, memwrite = 1'b0;
  logic [7:0]  p_index = 8'h00;
  logic [15:0] memaddr = 16'h0000, writedata = 16'h0000;
  logic        shift, swap, render_start, hsync, vsync;
  logic [8:0]  render_line;
  logic [7:0]  rgb;
  logic [15:0] memdata;

  line_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PALETTE_ADDR(PAL)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .p_index(p_index), .render_busy(render_busy),
    .shift(shift), .swap(swap), .render_start(render_start), .render_line(render_line),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .memaddr(memaddr), .memwrite(memwrite), .writedata(writedata), .memdata(memdata)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;

  // model state: t = pix_en ticks since reset; r_* = timing/index captured at the previous tick
  int          t;
  logic [7:0]  pal_m [256];
  bit          pal_known [256];
  bit          r_vis, r_hs, r_vs;
  logic [7:0]  r_idx;
  logic [7:0]  e_rgb;
  bit          e_hs, e_vs, e_rs, e_md_ok;
  logic [8:0]  e_rl;
  logic [15:0] e_md;
`ifdef LINE_SCANOUT_STATUS_EN
  bit          und;
  int          fc;
`endif

  function automatic bit vis_at(int h, int v);
    return (h < HV) && (v < VV);
  endfunction
  function automatic bit hs_at(int h);
    return !(h >= HV + HF && h < HV + HF + HS);
  endfunction
  function automatic bit vs_at(int v);
    return !(v >= VV + VF && v < VV + VF + VS);
  endfunction
  function automatic bit in_pal(logic [15:0] a);
    int ai, pi;
    ai = int'(a);
    pi = int'(PAL);
    return (ai >= pi) && (ai <= pi + 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (tick %0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  task automatic m_reset();
    t = 0;
    r_vis = 0; r_hs = 1; r_vs = 1; r_idx = 8'h00;
    e_rgb = 8'h00; e_hs = 1; e_vs = 1; e_rs = 0; e_rl = 9'd0;
    e_md = 16'h0000; e_md_ok = 1;
`ifdef LINE_SCANOUT_STATUS_EN
    und = 0; fc = 0;
`endif
  endtask

  task automatic compare();
    int h, v;
    bit ev;
    h = t % HT;
    v = (t / HT) % VT;
    ev = !rst && pix_en && (h == HV);
    check("shift", 32'(shift), 32'(!rst && pix_en && vis_at(h, v)));
    check("swap", 32'(swap), 32'(ev && ((v + 1) % VT) < VV));
    check("render_start", 32'(render_start), 32'(e_rs));
    check("render_line", 32'(render_line), 32'(e_rl));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("rgb", 32'(rgb), 32'(e_rgb));
    if (e_md_ok) check("memdata", 32'(memdata), 32'(e_md));
  endtask

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic step();
    int h, v, a;
    bit ev, swp, rsn;
    h = t % HT;
    v = (t / HT) % VT;
    a = int'(memaddr[7:0]);
    ev = !rst && pix_en && (h == HV);
    swp = ev && ((v + 1) % VT) < VV;
    rsn = ev && ((v + 2) % VT) < VV;
    if (rst) begin
      m_reset();
    end else begin
      if (in_pal(memaddr)) begin
        e_md = {8'h00, pal_m[a]};
        e_md_ok = pal_known[a];
      end
`ifdef LINE_SCANOUT_STATUS_EN
      else if (memaddr == PAL + 16'd256) begin
        e_md = {und, 5'b0, 10'(fc)};
        e_md_ok = 1;
      end
      und = (swp && render_busy) || (und && !(memaddr == PAL + 16'd256));
      if (pix_en && h == HT - 1 && v == VT - 1) fc = (fc + 1) % 1024;
`endif
      e_rs = rsn;
      if (rsn) e_rl = 9'((v + 2) % VT);
      if (pix_en) begin
        e_rgb = r_vis ? pal_m[r_idx] : 8'h00;
        e_hs = r_hs;
        e_vs = r_vs;
        r_vis = vis_at(h, v);
        r_idx = p_index;
        r_hs = hs_at(h);
        r_vs = vs_at(v);
        t++;
      end
    end
    if (in_pal(memaddr) && memwrite) begin
      pal_m[a] = writedata[7:0];
      pal_known[a] = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_tick();
    rst = 1; pix_en = 0; memwrite = 0; memaddr = 16'h0000; render_busy = 0;
    tick();
    rst = 0;
  endtask

  // One frame from reset at full rate (alt=0) or with pix_en on every other clk (alt=1).
  task automatic count_frame(input bit alt);
    int n, pos, hs_low, vs_low, shifts, swaps, starts;
    n = alt ? 2 * FRAME : FRAME;
    hs_low = 0; vs_low = 0; shifts = 0; swaps = 0; starts = 0;
    reset_tick();
    for (int i = 0; i < n; i++) begin
      pix_en = alt ? (i % 2 == 0) : 1'b1;
      p_index = 8'($urandom);
      pos = alt ? i / 2 : i;
      #1;
      if (shift) shifts++;
      if (swap) swaps++;
      tick();
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (render_start) starts++;
      if (pix_en && pos == 10 * HT + HV) begin
        check("ev_v10_start", 32'(render_start), 32'd1);
        check("ev_v10_line", 32'(render_line), 32'd12);
      end
      if (pix_en && pos == 18 * HT + HV) check("ev_v18_no_start", 32'(render_start), 32'd0);
      if (pix_en && pos == 28 * HT + HV) begin
        check("ev_v28_start", 32'(render_start), 32'd1);
        check("ev_v28_line", 32'(render_line), 32'd0);
      end
    end
    check("hsync_low_count", 32'(hs_low), alt ? 32'd480 : 32'd240);
    check("vsync_low_count", 32'(vs_low), alt ? 32'd192 : 32'd96);
    check("shift_count", 32'(shifts), 32'd640);
    check("swap_count", 32'(swaps), 32'd20);
    check("start_count", 32'(starts), 32'd20);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      pal_m[i] = 8'h00;
      pal_known[i] = 0;
    end
    m_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_memdata", 32'(memdata), 32'd0);
    check("rst_render_line", 32'(render_line), 32'd0);

    // fill the palette with counters held
    memwrite = 1;
    for (int i = 0; i < 256; i++) begin
      memaddr = PAL + 16'(i);
      writedata = 16'($urandom);
      tick();
    end

    // pixel (0,0) with index 0x15 -> 0xE0 after two ticks
    memaddr = PAL + 16'h0015; writedata = 16'hABE0;
    tick();
    memwrite = 0; memaddr = 16'h0000;
    pix_en = 1; p_index = 8'h15;
    tick();
    check("pix00_rgb_tick1", 32'(rgb), 32'd0);
    p_index = 8'h00;
    tick();
    check("pix00_rgb_tick2", 32'(rgb), 32'hE0);
    check("pix00_hsync", 32'(hsync), 32'd1);

    count_frame(1'b0);
    count_frame(1'b1);

    // reset in the middle of a line
    pix_en = 1;
    for (int i = 0; i < HT + 37; i++) begin
      p_index = 8'($urandom);
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    check("midrst_rgb", 32'(rgb), 32'd0);
    check("midrst_hsync", 32'(hsync), 32'd1);
    check("midrst_vsync", 32'(vsync), 32'd1);

    // same-clk write and read of one entry returns the old value
    pix_en = 0; memaddr = PAL + 16'h0040; memwrite = 1; writedata = 16'h0011;
    tick();
    writedata = 16'h0022;
    tick();
    check("rbw_old", 32'(memdata), 32'h0011);
    memwrite = 0;
    tick();
    check("rbw_new", 32'(memdata), 32'h0022);

`ifdef LINE_SCANOUT_STATUS_EN
    reset_tick();
    render_busy = 1; pix_en = 1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      p_index = 8'($urandom);
      tick();
    end
    pix_en = 0; render_busy = 0; memaddr = PAL + 16'h0100;
    tick();
    check("status_underrun_frames", 32'(memdata), 32'h8003);
    tick();
    check("status_cleared", 32'(memdata), 32'h0003);
`endif

    for (int i = 0; i < 9000; i++) begin
      int sel;
      rst = ($urandom_range(0, 1999) == 0);
      case ((i / 1000) % 3)
        0:       pix_en = 1;
        1:       pix_en = (i % 2 == 0);
        default: pix_en = ($urandom_range(0, 3) != 0);
      endcase
      p_index = 8'($urandom);
      render_busy = ($urandom_range(0, 7) == 0);
      sel = int'($urandom_range(0, 9));
      case (sel)
        6:       memaddr = PAL + 16'h0100;
        7:       memaddr = PAL - 16'h0001;
        8:       memaddr = 16'($urandom);
        9:       memaddr = PAL + 16'h0101;
        default: memaddr = PAL + 16'($urandom_range(0, 255));
      endcase
      memwrite = ($urandom_range(0, 3) == 0);
      writedata = 16'($urandom);
      tick();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
